// File: rtl/rca_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rca_cfg_decoder
// Purpose  : Receives decoded RCA configuration ops (funct3 001..101) over a
//            valid/ready handshake, holds each op until the configuration it
//            targets is no longer in use by an executing RCA, then commits it
//            into the per-RCA / shared configuration registers and pulses
//            cfg_done (qualified by cfg_err for rejected ops).
// Options  : RCA_CFG_RANGE_CHECK_EN - when defined, out-of-range RCA ids,
//            ports, indices and values are rejected with cfg_err=1. When not
//            defined, such writes are silently dropped and values truncated.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            cfg_valid/cfg_ready - op handshake from the issue stage
//            cfg_funct3/funct7   - op type / target RCA id
//            cfg_rs1/cfg_rs2     - op operands
//            rca_busy            - per-RCA executing flags
//            cfg_done/cfg_err    - one-cycle completion pulse / reject flag
//            src_addr_o          - source reg addr      [rca][fb][port]
//            dst_addr_o          - destination reg addr [rca][fb][port]
//            grid_sel_o          - grid mux selects
//            io_sel_o            - IO unit mux selects
//            res_sel_o           - result mux selects   [rca][fb][port]
//            io_use_o            - per-RCA read-port usage mask
// Revision : 1.0 - initial release
// ============================================================================
module rca_cfg_decoder #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int NUM_GRID_SELS   = 60,
  parameter int NUM_IO_SELS     = 36,
  parameter int RES_SEL_W       = 3
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    cfg_valid,
  output logic                                                    cfg_ready,
  input  logic [2:0]                                              cfg_funct3,
  input  logic [6:0]                                              cfg_funct7,
  input  logic [31:0]                                             cfg_rs1,
  input  logic [31:0]                                             cfg_rs2,
  input  logic [NUM_RCAS-1:0]                                     rca_busy,
  output logic                                                    cfg_done,
  output logic                                                    cfg_err,
  output logic [NUM_RCAS-1:0][1:0][NUM_READ_PORTS-1:0][4:0]       src_addr_o,
  output logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][4:0]      dst_addr_o,
  output logic [NUM_GRID_SELS-1:0][2:0]                           grid_sel_o,
  output logic [NUM_IO_SELS-1:0][3:0]                             io_sel_o,
  output logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] res_sel_o,
  output logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0]                 io_use_o
);

  localparam int RCA_W  = (NUM_RCAS > 1)      ? $clog2(NUM_RCAS)      : 1;
  localparam int GRID_W = (NUM_GRID_SELS > 1) ? $clog2(NUM_GRID_SELS) : 1;
  localparam int IO_W   = (NUM_IO_SELS > 1)   ? $clog2(NUM_IO_SELS)   : 1;

  // Result-mux select value meaning "write port unused".
  localparam logic [RES_SEL_W-1:0] C_RES_UNUSED = RES_SEL_W'(6);

  localparam logic [2:0] C_F3_CPU  = 3'b001;
  localparam logic [2:0] C_F3_GRID = 3'b010;
  localparam logic [2:0] C_F3_IO   = 3'b011;
  localparam logic [2:0] C_F3_RES  = 3'b100;
  localparam logic [2:0] C_F3_USE  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Held op. Only the low rs2 bits ever reach a config field; with range
  // checking the upper bits only matter as "non-zero", so they are folded.
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [31:0] r_rs1;
  logic [4:0]  r_rs2;
`ifdef RCA_CFG_RANGE_CHECK_EN
  logic        r_rs2_hi;
`endif

  logic        r_done;
  logic        r_err;

  logic [NUM_RCAS-1:0][1:0][NUM_READ_PORTS-1:0][4:0]           r_src_addr;
  logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][4:0]          r_dst_addr;
  logic [NUM_GRID_SELS-1:0][2:0]                               r_grid_sel;
  logic [NUM_IO_SELS-1:0][3:0]                                 r_io_sel;
  logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] r_res_sel;
  logic [NUM_RCAS-1:0][NUM_READ_PORTS-1:0]                     r_io_use;

  // --------------------------------------------------------------------------
  // Decode of the held op
  // --------------------------------------------------------------------------
  logic             w_op_cpu, w_op_grid, w_op_io, w_op_res, w_op_use;
  logic             w_is_cfg, w_per_rca;
  logic             w_rca_ok, w_tgt_ok, w_reject, w_write;
  logic             w_busy_sel, w_conflict;
  logic [RCA_W-1:0] w_rca;
  logic [2:0]       w_port;
  logic             w_src;      // CPU-reg op: 1 = source, 0 = destination
  logic             w_fb_cpu;
  logic             w_fb_res;

  assign w_op_cpu  = (r_funct3 == C_F3_CPU);
  assign w_op_grid = (r_funct3 == C_F3_GRID);
  assign w_op_io   = (r_funct3 == C_F3_IO);
  assign w_op_res  = (r_funct3 == C_F3_RES);
  assign w_op_use  = (r_funct3 == C_F3_USE);
  assign w_is_cfg  = w_op_cpu | w_op_grid | w_op_io | w_op_res | w_op_use;
  assign w_per_rca = w_op_cpu | w_op_res | w_op_use;

  assign w_rca    = r_funct7[RCA_W-1:0];
  assign w_port   = r_rs1[2:0];
  assign w_src    = r_rs1[3];
  assign w_fb_cpu = r_rs1[4];
  assign w_fb_res = r_rs1[3];

  assign w_rca_ok = (32'(r_funct7) < 32'(NUM_RCAS));

  // Is the addressed register actually present?
  always_comb begin
    w_tgt_ok = 1'b0;
    if (w_op_cpu) begin
      w_tgt_ok = w_rca_ok &&
                 (w_src ? (32'(w_port) < 32'(NUM_READ_PORTS))
                        : (32'(w_port) < 32'(NUM_WRITE_PORTS)));
    end else if (w_op_res) begin
      w_tgt_ok = w_rca_ok && (32'(w_port) < 32'(NUM_WRITE_PORTS));
    end else if (w_op_use) begin
      w_tgt_ok = w_rca_ok;
    end else if (w_op_grid) begin
      w_tgt_ok = (r_rs1 < 32'(NUM_GRID_SELS));
    end else if (w_op_io) begin
      w_tgt_ok = (r_rs1 < 32'(NUM_IO_SELS));
    end
  end

`ifdef RCA_CFG_RANGE_CHECK_EN
  logic w_val_ok;
  always_comb begin
    w_val_ok = 1'b1;
    if (w_op_io) begin
      // Legal IO select values are 0..11.
      w_val_ok = !r_rs2_hi && !r_rs2[4] && (r_rs2[3:0] < 4'd12);
    end else if (w_op_res) begin
      // Legal result select values are 0..6.
      w_val_ok = !r_rs2_hi && (r_rs2[4:3] == 2'b00) && (r_rs2[2:0] != 3'd7);
    end
  end
  assign w_reject = !w_is_cfg || !w_tgt_ok || !w_val_ok;
  assign w_write  = !w_reject;
`else
  assign w_reject = !w_is_cfg;
  assign w_write  = w_is_cfg && w_tgt_ok;
`endif

  // Per-RCA ops only wait for their own RCA; shared mux config waits for
  // every RCA. An RCA id with no busy bit cannot conflict. Rejected ops
  // never write anything, so they never need to wait.
  assign w_busy_sel = w_rca_ok && rca_busy[w_rca];
  assign w_conflict = !w_reject && (w_per_rca ? w_busy_sel : (|rca_busy));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_conflict) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Op capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_rs1    <= 32'd0;
      r_rs2    <= 5'd0;
`ifdef RCA_CFG_RANGE_CHECK_EN
      r_rs2_hi <= 1'b0;
`endif
    end else if ((r_state == S_IDLE) && cfg_valid) begin
      r_funct3 <= cfg_funct3;
      r_funct7 <= cfg_funct7;
      r_rs1    <= cfg_rs1;
      r_rs2    <= cfg_rs2[4:0];
`ifdef RCA_CFG_RANGE_CHECK_EN
      r_rs2_hi <= |cfg_rs2[31:5];
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers and completion pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_grid_sel <= '0;
      r_io_sel   <= '0;
      r_res_sel  <= {(NUM_RCAS*2*NUM_WRITE_PORTS){C_RES_UNUSED}};
      r_io_use   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_COMMIT) begin
        r_done <= 1'b1;
        r_err  <= w_reject;
        if (w_write) begin
          if (w_op_cpu) begin
            if (w_src) begin
              r_src_addr[w_rca][w_fb_cpu][w_port] <= r_rs2[4:0];
            end else begin
              r_dst_addr[w_rca][w_fb_cpu][w_port] <= r_rs2[4:0];
            end
          end
          if (w_op_grid) begin
            r_grid_sel[r_rs1[GRID_W-1:0]] <= r_rs2[2:0];
          end
          if (w_op_io) begin
            r_io_sel[r_rs1[IO_W-1:0]] <= r_rs2[3:0];
          end
          if (w_op_res) begin
            r_res_sel[w_rca][w_fb_res][w_port] <= r_rs2[RES_SEL_W-1:0];
          end
          if (w_op_use) begin
            r_io_use[w_rca] <= r_rs1[NUM_READ_PORTS-1:0];
          end
        end
      end
    end
  end

  assign cfg_done   = r_done;
  assign cfg_err    = r_err;
  assign src_addr_o = r_src_addr;
  assign dst_addr_o = r_dst_addr;
  assign grid_sel_o = r_grid_sel;
  assign io_sel_o   = r_io_sel;
  assign res_sel_o  = r_res_sel;
  assign io_use_o   = r_io_use;

endmodule
`default_nettype wire

// File: tb/tb_rca_cfg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_cfg_decoder
// Purpose  : Directed self-checking bench for rca_cfg_decoder. Expected
//            completion flags go into a scoreboard queue when an op is sent
//            and are popped when cfg_done appears; config outputs are checked
//            against a reference model of the configuration registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_cfg_decoder;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_funct3;
  logic [6:0]  cfg_funct7;
  logic [31:0] cfg_rs1;
  logic [31:0] cfg_rs2;
  logic [3:0]  rca_busy;
  logic        cfg_done;
  logic        cfg_err;

  logic [3:0][1:0][4:0][4:0] src_addr_o, m_src;
  logic [3:0][1:0][4:0][4:0] dst_addr_o, m_dst;
  logic [59:0][2:0]          grid_sel_o, m_grid;
  logic [35:0][3:0]          io_sel_o,   m_io;
  logic [3:0][1:0][4:0][2:0] res_sel_o,  m_res;
  logic [3:0][4:0]           io_use_o,   m_use;

  int n_tests = 0;
  int n_fail  = 0;
  logic q_err[$];

  rca_cfg_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_funct3 (cfg_funct3),
    .cfg_funct7 (cfg_funct7),
    .cfg_rs1    (cfg_rs1),
    .cfg_rs2    (cfg_rs2),
    .rca_busy   (rca_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .src_addr_o (src_addr_o),
    .dst_addr_o (dst_addr_o),
    .grid_sel_o (grid_sel_o),
    .io_sel_o   (io_sel_o),
    .res_sel_o  (res_sel_o),
    .io_use_o   (io_use_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src  = '0;
    m_dst  = '0;
    m_grid = '0;
    m_io   = '0;
    m_res  = {40{3'd6}};
    m_use  = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".src"},  256'(src_addr_o), 256'(m_src));
    chk({tag, ".dst"},  256'(dst_addr_o), 256'(m_dst));
    chk({tag, ".grid"}, 256'(grid_sel_o), 256'(m_grid));
    chk({tag, ".io"},   256'(io_sel_o),   256'(m_io));
    chk({tag, ".res"},  256'(res_sel_o),  256'(m_res));
    chk({tag, ".use"},  256'(io_use_o),   256'(m_use));
  endtask

  // Present one op at a negedge; it is accepted at the following posedge.
  task automatic send(input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic exp_err, input bit push);
    @(negedge clk);
    chk("ready_before_send", 256'(cfg_ready), 256'(1));
    cfg_valid  = 1'b1;
    cfg_funct3 = f3;
    cfg_funct7 = f7;
    cfg_rs1    = r1;
    cfg_rs2    = r2;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    if (push) q_err.push_back(exp_err);
  endtask

  // Op is held: no ready, no done, config unchanged.
  task automatic stall_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".ready_low"}, 256'(cfg_ready), 256'(0));
      chk({tag, ".no_done"},   256'(cfg_done),  256'(0));
      check_all({tag, ".hold"});
    end
  endtask

  // Count negedges until cfg_done; compare latency and the scoreboard flag.
  task automatic wait_done(input int exp_lat, input string tag);
    int  lat;
    bit  found;
    logic e;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (cfg_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, ".done_seen"}, 256'(found), 256'(1));
    if (found) begin
      chk({tag, ".latency"},  256'(lat), 256'(exp_lat));
      chk({tag, ".sb_depth"}, 256'(q_err.size()), 256'(1));
      if (q_err.size() > 0) begin
        e = q_err.pop_front();
        chk({tag, ".err"}, 256'(cfg_err), 256'(e));
      end
      @(negedge clk);
      chk({tag, ".done_one_cycle"}, 256'(cfg_done), 256'(0));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_funct3 = 3'd0;
    cfg_funct7 = 7'd0;
    cfg_rs1    = 32'd0;
    cfg_rs2    = 32'd0;
    rca_busy   = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("reset.ready", 256'(cfg_ready), 256'(1));
    chk("reset.done",  256'(cfg_done),  256'(0));
    chk("reset.err",   256'(cfg_err),   256'(0));
    check_all("reset");

    // CPU reg, source: rs1=0x18 -> port 0, src, fb 1.
    send(3'b001, 7'd2, 32'h18, 32'd7, 1'b0, 1'b1);
    wait_done(3, "cpu_src");
    m_src[2][1][0] = 5'd7;
    check_all("cpu_src");

    // CPU reg, destination: rs1=0x02 -> port 2, dst, fb 0.
    send(3'b001, 7'd0, 32'h02, 32'h1F, 1'b0, 1'b1);
    wait_done(3, "cpu_dst");
    m_dst[0][0][2] = 5'd31;
    check_all("cpu_dst");

    // Result mux stalled by its own RCA being busy.
    rca_busy = 4'b0010;
    send(3'b100, 7'd1, 32'h3, 32'd4, 1'b0, 1'b1);
    stall_check(5, "res_stall");
    rca_busy = 4'b0000;
    wait_done(2, "res_stall");
    m_res[1][0][3] = 3'd4;
    check_all("res_stall");

    // IO use on RCA 3 while only RCA 0 is busy: no stall.
    rca_busy = 4'b0001;
    send(3'b101, 7'd3, 32'h15, 32'd0, 1'b0, 1'b1);
    wait_done(3, "use_nostall");
    rca_busy = 4'b0000;
    m_use[3] = 5'h15;
    check_all("use_nostall");

    // Shared grid mux stalls while any RCA is busy; top index.
    rca_busy = 4'b1000;
    send(3'b010, 7'd0, 32'd59, 32'd5, 1'b0, 1'b1);
    stall_check(3, "grid_stall");
    rca_busy = 4'b0000;
    wait_done(2, "grid_stall");
    m_grid[59] = 3'd5;
    check_all("grid_stall");

    // Non-config funct3 rejected, never stalls.
    rca_busy = 4'b1111;
    send(3'b110, 7'd0, 32'd0, 32'd1, 1'b1, 1'b1);
    wait_done(3, "f3_110");
    check_all("f3_110");
    send(3'b000, 7'd1, 32'h18, 32'd3, 1'b1, 1'b1);
    wait_done(3, "f3_000");
    check_all("f3_000");
    rca_busy = 4'b0000;

    // IO mux, out-of-range index.
`ifdef RCA_CFG_RANGE_CHECK_EN
    send(3'b011, 7'd0, 32'd40, 32'd3, 1'b1, 1'b1);
`else
    send(3'b011, 7'd0, 32'd40, 32'd3, 1'b0, 1'b1);
`endif
    wait_done(3, "io_oor");
    check_all("io_oor");

    // IO mux, last legal index and value.
    send(3'b011, 7'd0, 32'd35, 32'd11, 1'b0, 1'b1);
    wait_done(3, "io_last");
    m_io[35] = 4'd11;
    check_all("io_last");

    // Reset while an op is held: op discarded, no completion.
    rca_busy = 4'b0001;
    send(3'b001, 7'd0, 32'h08, 32'd9, 1'b0, 1'b0);
    stall_check(2, "rst_hold");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rca_busy = 4'b0000;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_hold.no_done", 256'(cfg_done), 256'(0));
    end
    chk("rst_hold.ready", 256'(cfg_ready), 256'(1));
    check_all("rst_hold");

    // Unit still works after the mid-op reset.
    send(3'b101, 7'd0, 32'h1F, 32'd0, 1'b0, 1'b1);
    wait_done(3, "after_rst");
    m_use[0] = 5'h1F;
    check_all("after_rst");

    chk("sb_empty", 256'(q_err.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
